ofs_plat_avalon_mem_rdwr_arb_sched: RTL
=======================================

Name: ofs_plat_avalon_mem_rdwr_arb_sched

Overview:
- Burst-aware round-robin scheduler that shares one split-bus read/write Avalon sink among NUM_PORTS sources.
- Issues one-hot grants independently on the read and write request channels.
- Locks write grants for the duration of a write burst.
- Limits each port's outstanding read beats with a credit counter, so a slow port cannot monopolise response buffering.
- Sits ahead of the request datapath mux in emulated or real host-channel multiplexing; the mux steers data using the grant index.

Parameters:
- NUM_PORTS, 4, number of source ports (2..16).
- BURST_CNT_WIDTH, 7, width of the Avalon burstcount field.
- RD_CREDITS, 64, maximum outstanding read beats per port (must be at least 2^(BURST_CNT_WIDTH-1)).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- rd_req  in  NUM_PORTS  per-port read request valid
- rd_burstcount  in  NUM_PORTS*BURST_CNT_WIDTH  per-port read burst length, port i at slice i
- rd_sink_ready  in  1  shared sink accepts a read request this cycle
- rd_grant  out  NUM_PORTS  one-hot read grant
- rd_grant_idx  out  $clog2(NUM_PORTS)  encoded read grant
- rd_rsp_valid  in  1  one read response beat returned
- rd_rsp_port  in  $clog2(NUM_PORTS)  port owning that response beat
- wr_req  in  NUM_PORTS  per-port write beat valid
- wr_burstcount  in  NUM_PORTS*BURST_CNT_WIDTH  burst length, sampled on the first beat only
- wr_sink_ready  in  1  shared sink accepts a write beat
- wr_grant  out  NUM_PORTS  one-hot write grant
- wr_grant_idx  out  $clog2(NUM_PORTS)  encoded write grant
- wr_locked  out  1  a write burst is in progress
- rd_credit_err  out  1  sticky: a response arrived for a port with full credits

Behaviour:
- **Reset:** grants 0, grant indices 0, rr pointers 0, wr_locked 0, beat counter 0, all credits RD_CREDITS, rd_credit_err 0. Reset asserted mid-burst abandons the burst; no grant is issued until reset_n deasserts.
- **Grants are combinational:** a grant is computed from the registered state and the current inputs. A request transfers in a cycle where both req[i] and grant[i] are 1. A grant is only asserted when the corresponding sink_ready is 1; grants are 0 otherwise.
- **Read eligibility:** port i is eligible when rd_req[i]=1 and credit[i] >= rd_burstcount[i]. A burstcount of 0 is treated as 1.
- **Read arbitration:** round-robin over eligible ports, starting at rd_ptr. After a grant to port i, rd_ptr <= (i+1) mod NUM_PORTS. rd_ptr holds when there is no grant.
- **Credit update:** each cycle, credit[i] <= credit[i] - (granted burst on i) + (rd_rsp_valid && rd_rsp_port==i). A grant and a response on the same port in the same cycle apply the net change.
- **Credit overflow:** a response that would push a credit above RD_CREDITS saturates at RD_CREDITS and sets rd_credit_err, which stays set until reset.
- **Write FSM states:** IDLE, BURST.
  - IDLE: round-robin over wr_req from wr_ptr.
  - On a granted beat with burstcount B > 1: latch the port, set remaining = B-1, go to BURST, wr_locked=1.
  - On a granted beat with B = 1: stay in IDLE; advance wr_ptr.
  - BURST: wr_grant is driven only to the locked port, and only when wr_sink_ready=1. Each accepted beat decrements remaining.
  - When the beat with remaining==1 is accepted: go to IDLE, wr_locked <= 0, wr_ptr <= locked+1. The next burst can be granted in the following cycle.
  - Other ports' wr_req are ignored while in BURST. wr_burstcount is ignored on non-first beats.
- **Channel independence:** read and write channels are fully independent; simultaneous grants are legal.
- **Latency:** zero cycles from request to grant when the port is eligible and has priority. Worst-case wait is (NUM_PORTS-1) grants on reads, or (NUM_PORTS-1) full bursts on writes.

Decomposition:
- Shared package ofs_plat_avalon_arb_sched_pkg holds:
  - t_port_idx, t_burstcnt, t_rd_credit (width $clog2(RD_CREDITS+1)) typedefs;
  - the write FSM state enum.
- One sub-module, ofs_plat_prim_rr_arb: a parameterised combinational round-robin picker taking req vector and pointer, returning a one-hot grant and an index. It is instantiated twice.

Test Plan:
- NUM_PORTS=4, all rd_req=1, burstcount=1, rd_sink_ready=1 for 8 cycles -> rd_grant_idx sequence 0,1,2,3,0,1,2,3.
- Port 2 writes burstcount=4 while ports 0 and 3 request -> wr_grant stays on port 2 for 4 accepted beats. With wr_sink_ready toggling, only ready cycles count. The next grant goes to port 3, then 0.
- RD_CREDITS=8: port 1 is granted two bursts of 4 with no responses -> the third request (burst 1) is blocked and other ports are served. One response to port 1 -> port 1 is re-eligible for burst 1 the next cycle.
- Grant of burst 4 to port 0 and a response for port 0 in the same cycle -> credit goes from 8 to 5.
- Response for a port whose credits are full -> credit stays 8 and rd_credit_err=1 and sticky.
- reset_n dropped asynchronously mid-burst (remaining=2) -> grants 0 immediately, wr_locked=0. After release, a fresh arbitration starts from pointer 0.

Source files
------------

// File: rtl/ofs_plat_avalon_arb_sched_pkg.sv
// Shared types and helpers for the Avalon read/write arbitration scheduler.
package ofs_plat_avalon_arb_sched_pkg;

    // Default configuration of the scheduler
    localparam int NUM_PORTS_DFLT       = 4;
    localparam int BURST_CNT_WIDTH_DFLT = 7;
    localparam int RD_CREDITS_DFLT      = 64;

    // Field types for the default configuration; the top sizes its own
    // state from its parameters so that other configurations also work.
    typedef logic [$clog2(NUM_PORTS_DFLT)-1:0]    t_port_idx;
    typedef logic [BURST_CNT_WIDTH_DFLT-1:0]      t_burstcnt;
    typedef logic [$clog2(RD_CREDITS_DFLT+1)-1:0] t_rd_credit;

    // Write channel state: choosing a port, or locked to one for a burst
    typedef enum logic {
        WR_IDLE,
        WR_BURST
    } t_wr_state;

    // Avalon burstcount of zero is treated as a single beat
    function automatic int eff_burst(input int bc);
        return (bc == 0) ? 1 : bc;
    endfunction

endpackage

// File: rtl/ofs_plat_prim_rr_arb.sv
// Combinational round-robin picker: first requester at or after ptr wins.
module ofs_plat_prim_rr_arb
    import ofs_plat_avalon_arb_sched_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
)(
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx
);

    // Scan ports starting at ptr, wrapping, and grant the first requester
    always_comb begin
        int   p;
        logic found;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        p     = 0;
        for (int off = 0; off < N; off++) begin
            p = (int'(ptr) + off) % N;
            if (!found && req[p]) begin
                found    = 1'b1;
                grant[p] = 1'b1;
                idx      = IDX_W'(p);
            end
        end
    end

endmodule

// File: rtl/ofs_plat_avalon_mem_rdwr_arb_sched.sv
// Burst-aware round-robin scheduler sharing one split read/write Avalon sink.
module ofs_plat_avalon_mem_rdwr_arb_sched
    import ofs_plat_avalon_arb_sched_pkg::*;
#(
    parameter int NUM_PORTS       = NUM_PORTS_DFLT,
    parameter int BURST_CNT_WIDTH = BURST_CNT_WIDTH_DFLT,
    parameter int RD_CREDITS      = RD_CREDITS_DFLT
)(
    input  logic                                 clk,
    input  logic                                 reset_n,

    input  logic [NUM_PORTS-1:0]                 rd_req,
    input  logic [NUM_PORTS*BURST_CNT_WIDTH-1:0] rd_burstcount,
    input  logic                                 rd_sink_ready,
    output logic [NUM_PORTS-1:0]                 rd_grant,
    output logic [$clog2(NUM_PORTS)-1:0]         rd_grant_idx,
    input  logic                                 rd_rsp_valid,
    input  logic [$clog2(NUM_PORTS)-1:0]         rd_rsp_port,

    input  logic [NUM_PORTS-1:0]                 wr_req,
    input  logic [NUM_PORTS*BURST_CNT_WIDTH-1:0] wr_burstcount,
    input  logic                                 wr_sink_ready,
    output logic [NUM_PORTS-1:0]                 wr_grant,
    output logic [$clog2(NUM_PORTS)-1:0]         wr_grant_idx,
    output logic                                 wr_locked,

    output logic                                 rd_credit_err
);

    localparam int IDX_W  = $clog2(NUM_PORTS);
    localparam int CRED_W = $clog2(RD_CREDITS + 1);

    function automatic logic [IDX_W-1:0] idx_after(input logic [IDX_W-1:0] i);
        return IDX_W'((int'(i) + 1) % NUM_PORTS);
    endfunction

    // ---------------- Read channel ----------------
    logic [IDX_W-1:0]     rd_ptr;
    logic [CRED_W-1:0]    rd_credit     [NUM_PORTS];
    logic [CRED_W-1:0]    rd_credit_nxt [NUM_PORTS];
    int                   rd_need       [NUM_PORTS];
    logic [NUM_PORTS-1:0] rd_eligible;
    logic                 rd_overflow;

    // A port may compete only if its credits cover the whole burst it asks for
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            rd_need[i]     = eff_burst(int'(rd_burstcount[i*BURST_CNT_WIDTH +: BURST_CNT_WIDTH]));
            rd_eligible[i] = rd_req[i] && (int'(rd_credit[i]) >= rd_need[i])
                             && rd_sink_ready && reset_n;
        end
    end

    ofs_plat_prim_rr_arb #(.N(NUM_PORTS), .IDX_W(IDX_W)) rd_arb (
        .req   (rd_eligible),
        .ptr   (rd_ptr),
        .grant (rd_grant),
        .idx   (rd_grant_idx)
    );

    // Net credit change per port: minus granted beats, plus a returned beat
    always_comb begin
        int c;
        c           = 0;
        rd_overflow = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            c = int'(rd_credit[i]);
            if (rd_grant[i]) begin
                c = c - rd_need[i];
            end
            if (rd_rsp_valid && (int'(rd_rsp_port) == i)) begin
                c = c + 1;
            end
            if (c > RD_CREDITS) begin
                c           = RD_CREDITS;
                rd_overflow = 1'b1;
            end
            rd_credit_nxt[i] = CRED_W'(c);
        end
    end

    // Read pointer, credit counters and the sticky over-return flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr        <= '0;
            rd_credit_err <= 1'b0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                rd_credit[i] <= CRED_W'(RD_CREDITS);
            end
        end else begin
            if (|rd_grant) begin
                rd_ptr <= idx_after(rd_grant_idx);
            end
            if (rd_overflow) begin
                rd_credit_err <= 1'b1;
            end
            for (int i = 0; i < NUM_PORTS; i++) begin
                rd_credit[i] <= rd_credit_nxt[i];
            end
        end
    end

    // ---------------- Write channel ----------------
    t_wr_state                  wr_state, wr_state_nxt;
    logic [IDX_W-1:0]           wr_ptr, wr_ptr_nxt;
    logic [IDX_W-1:0]           wr_lock, wr_lock_nxt;
    logic [BURST_CNT_WIDTH-1:0] wr_remaining, wr_remaining_nxt;
    logic [NUM_PORTS-1:0]       wr_arb_req, wr_arb_grant;
    logic [IDX_W-1:0]           wr_arb_idx;

    // Only idle, ready, out-of-reset cycles open arbitration between ports
    always_comb begin
        wr_arb_req = '0;
        if ((wr_state == WR_IDLE) && wr_sink_ready && reset_n) begin
            wr_arb_req = wr_req;
        end
    end

    ofs_plat_prim_rr_arb #(.N(NUM_PORTS), .IDX_W(IDX_W)) wr_arb (
        .req   (wr_arb_req),
        .ptr   (wr_ptr),
        .grant (wr_arb_grant),
        .idx   (wr_arb_idx)
    );

    // Write FSM: pick a port, then hold the grant on it until its burst ends
    always_comb begin
        int b;
        wr_state_nxt     = wr_state;
        wr_ptr_nxt       = wr_ptr;
        wr_lock_nxt      = wr_lock;
        wr_remaining_nxt = wr_remaining;
        wr_grant         = '0;
        wr_grant_idx     = '0;
        b                = 1;
        case (wr_state)
            WR_IDLE: begin
                wr_grant     = wr_arb_grant;
                wr_grant_idx = wr_arb_idx;
                if (|wr_arb_grant) begin
                    b = eff_burst(int'(wr_burstcount[int'(wr_arb_idx)*BURST_CNT_WIDTH +: BURST_CNT_WIDTH]));
                    if (b > 1) begin
                        wr_state_nxt     = WR_BURST;
                        wr_lock_nxt      = wr_arb_idx;
                        wr_remaining_nxt = BURST_CNT_WIDTH'(b - 1);
                    end else begin
                        wr_ptr_nxt = idx_after(wr_arb_idx);
                    end
                end
            end
            WR_BURST: begin
                wr_grant_idx = wr_lock;
                if (wr_sink_ready && reset_n) begin
                    wr_grant[wr_lock] = 1'b1;
                    if (wr_req[wr_lock]) begin
                        wr_remaining_nxt = wr_remaining - 1'b1;
                        if (wr_remaining == BURST_CNT_WIDTH'(1)) begin
                            wr_state_nxt = WR_IDLE;
                            wr_ptr_nxt   = idx_after(wr_lock);
                        end
                    end
                end
            end
            default: begin
                wr_state_nxt = WR_IDLE;
            end
        endcase
    end

    // Write FSM state register; reset abandons any burst in progress
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_state     <= WR_IDLE;
            wr_ptr       <= '0;
            wr_lock      <= '0;
            wr_remaining <= '0;
        end else begin
            wr_state     <= wr_state_nxt;
            wr_ptr       <= wr_ptr_nxt;
            wr_lock      <= wr_lock_nxt;
            wr_remaining <= wr_remaining_nxt;
        end
    end

    assign wr_locked = (wr_state == WR_BURST);

endmodule
